// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer in front of the data cache RAM.
// Handles one request at a time: load lane extraction and read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] dc_raddr_o,
  input  logic [DATA_W-1:0] dc_rdata_i,
  output logic [ADDR_W-1:0] dc_waddr_o,
  output logic [DATA_W-1:0] dc_wdata_o,
  output logic              dc_we_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_MERGE  = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  state_e              state_q;
  logic                store_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [HALF_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;
  logic [ADDR_W-1:0]   dc_raddr_q;
  logic [ADDR_W-1:0]   dc_waddr_q;
  logic [DATA_W-1:0]   dc_wdata_q;
  logic                dc_we_q;

  // Reserved size or a half/word address not aligned to its own size.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed little-endian lane and extend it to a full word.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        size,
                                                    input logic [1:0]        lane,
                                                    input logic              uns);
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    logic [DATA_W-1:0] res;
    b = BYTE_W'(word >> {lane, 3'b000});
    h = HALF_W'(word >> {lane[1], 4'b0000});
    unique case (size)
      SZ_BYTE: res = uns ? DATA_W'(b) : {{(DATA_W-BYTE_W){b[BYTE_W-1]}}, b};
      SZ_HALF: res = uns ? DATA_W'(h) : {{(DATA_W-HALF_W){h[HALF_W-1]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overwrite the addressed byte or half lane of the word read from the cache.
  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] word,
                                                   input logic [HALF_W-1:0] wdata,
                                                   input logic [1:0]        size,
                                                   input logic [1:0]        lane);
    logic [DATA_W-1:0] mask;
    logic [4:0]        sh;
    if (size == SZ_BYTE) begin
      sh   = {lane, 3'b000};
      mask = DATA_W'(8'hFF) << sh;
    end else begin
      sh   = {lane[1], 4'b0000};
      mask = DATA_W'(16'hFFFF) << sh;
    end
    return (word & ~mask) | ((DATA_W'(wdata) << sh) & mask);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      dc_raddr_q  <= '0;
      dc_waddr_q  <= '0;
      dc_wdata_q  <= '0;
      dc_we_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            store_q <= req_store_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i[HALF_W-1:0];
            if (req_misaligned(req_size_i, req_addr_i[1:0])) begin
              resp_err_q  <= 1'b1;
              resp_data_q <= '0;
              state_q     <= S_RESP;
            end else begin
              resp_err_q <= 1'b0;
              dc_raddr_q <= req_addr_i >> 2;
              state_q    <= S_ACCESS;
              // Full-word stores need no read, so the write goes out during ACCESS.
              if (req_store_i && (req_size_i == SZ_WORD)) begin
                dc_we_q    <= 1'b1;
                dc_waddr_q <= {req_addr_i[ADDR_W-1:2], 2'b00};
                dc_wdata_q <= req_wdata_i;
              end
            end
          end
        end

        S_ACCESS: begin
          dc_raddr_q <= '0;
          if (!store_q) begin
            resp_data_q <= load_extend(dc_rdata_i, size_q, addr_q[1:0], uns_q);
            state_q     <= S_RESP;
          end else if (size_q == SZ_WORD) begin
            dc_we_q     <= 1'b0;
            dc_waddr_q  <= '0;
            dc_wdata_q  <= '0;
            resp_data_q <= '0;
            state_q     <= S_RESP;
          end else begin
            // dc_wdata_q acts as the merge register for the read-modify-write.
            dc_we_q    <= 1'b1;
            dc_waddr_q <= {addr_q[ADDR_W-1:2], 2'b00};
            dc_wdata_q <= merge_lane(dc_rdata_i, wdata_q, size_q, addr_q[1:0]);
            state_q    <= S_MERGE;
          end
        end

        S_MERGE: begin
          dc_we_q     <= 1'b0;
          dc_waddr_q  <= '0;
          dc_wdata_q  <= '0;
          resp_data_q <= '0;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          if (resp_ready_i) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign dc_raddr_o   = dc_raddr_q;
  assign dc_waddr_o   = dc_waddr_q;
  assign dc_wdata_o   = dc_wdata_q;
  // A reset arriving mid-write must suppress the write at that same edge.
  assign dc_we_o      = dc_we_q & ~rst_i;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: cache RAM model, transaction-level reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NWORDS = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic [ADDR_W-1:0] dc_raddr;
  logic [DATA_W-1:0] dc_rdata;
  logic [ADDR_W-1:0] dc_waddr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_we;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_store_i    (req_store),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .dc_raddr_o     (dc_raddr),
    .dc_rdata_i     (dc_rdata),
    .dc_waddr_o     (dc_waddr),
    .dc_wdata_o     (dc_wdata),
    .dc_we_o        (dc_we)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cache RAM seen by the DUT.
  logic [DATA_W-1:0] seed    [NWORDS];
  logic [DATA_W-1:0] mem     [NWORDS];
  logic [DATA_W-1:0] ref_mem [NWORDS];
  logic              env_init = 1'b0;

  assign dc_rdata = mem[dc_raddr[5:0]];

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= seed[i];
      env_init <= 1'b1;
    end else if (dc_we) begin
      mem[dc_waddr[7:2]] <= dc_wdata;
    end
  end

  // Reference model: one transaction at a time, tracked by cycles since accept.
  logic        started = 1'b0;
  logic        busy    = 1'b0;
  int          cyc     = 0;
  int          m_lat   = 0;
  logic        m_write = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_word  = '0;
  logic [31:0] m_addr  = '0;
  int          acc_cnt = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    logic [7:0]  by [4];
    logic [31:0] w;
    logic [31:0] v;
    int          lo;
    if (!started) begin
      for (int i = 0; i < NWORDS; i++) ref_mem[i] = seed[i];
    end
    if (busy && m_write && (cyc == m_lat - 1) && !rst) ref_mem[m_addr[7:2]] = m_word;
    if (rst) begin
      busy    = 1'b0;
      started = 1'b1;
    end else if (!busy) begin
      if (req_valid && started) begin
        m_addr = req_addr;
        m_err  = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        m_lat  = m_err ? 1 : ((!req_store || req_size == 2'b10) ? 2 : 3);
        m_write = req_store && !m_err;
        w = ref_mem[req_addr[7:2]];
        for (int j = 0; j < 4; j++) by[j] = w[8*j +: 8];
        lo = int'(req_addr[1]) * 2;
        v = 32'h0;
        if (!m_err && !req_store) begin
          if (req_size == 2'b00) begin
            v = {24'h0, by[req_addr[1:0]]};
            if (!req_unsigned && v[7]) v = v | 32'hFFFF_FF00;
          end else if (req_size == 2'b01) begin
            v = {16'h0, by[lo+1], by[lo]};
            if (!req_unsigned && v[15]) v = v | 32'hFFFF_0000;
          end else begin
            v = w;
          end
        end
        if (req_size == 2'b00) begin
          by[req_addr[1:0]] = req_wdata[7:0];
        end else if (req_size == 2'b01) begin
          by[lo]   = req_wdata[7:0];
          by[lo+1] = req_wdata[15:8];
        end
        m_word = (req_size == 2'b10) ? req_wdata : {by[3], by[2], by[1], by[0]};
        m_data = v;
        busy   = 1'b1;
        cyc    = 1;
        acc_cnt++;
      end
    end else if (cyc >= m_lat) begin
      if (resp_ready) begin
        busy = 1'b0;
        done_cnt++;
      end
    end else begin
      cyc++;
    end
  end

  // Per-cycle comparison of every meaningful DUT output against the model.
  int          we_cnt = 0;
  logic [31:0] last_d = '0;
  logic        last_e = 1'b0;

  always @(negedge clk) begin
    logic exp_rv;
    logic exp_we;
    if (started) begin
      exp_rv = busy && (cyc >= m_lat);
      exp_we = busy && m_write && (cyc == m_lat - 1) && !rst;
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      chk("dc_we", 32'(dc_we), 32'(exp_we));
      if (exp_rv) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
      if (exp_we) begin
        chk("dc_waddr", dc_waddr, {m_addr[31:2], 2'b00});
        chk("dc_wdata", dc_wdata, m_word);
      end
      if (busy && !m_err && cyc == 1) chk("dc_raddr", dc_raddr, m_addr >> 2);
      if (!busy || exp_rv) begin
        chk("idle_raddr", dc_raddr, 32'h0);
        chk("idle_waddr", dc_waddr, 32'h0);
        chk("idle_wdata", dc_wdata, 32'h0);
      end
    end
    if (dc_we) we_cnt++;
    if (resp_valid && resp_ready) begin
      last_d = resp_data;
      last_e = resp_err;
    end
  end

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Issue one request and wait for its response; resp_ready held low for
  // 'hold' response cycles. Called and returns just after a rising edge.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] d, output logic e);
    int a0;
    int k;
    int seen;
    d = '0;
    e = 1'b0;
    a0 = acc_cnt;
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    resp_ready   = (hold == 0);
    k = 0;
    while (acc_cnt == a0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    idle_inputs();
    if (acc_cnt == a0) begin
      chk("accept_timeout", 32'(k), 32'(0));
      return;
    end
    a0 = done_cnt;
    seen = 0;
    k = 0;
    while (done_cnt == a0 && k < 50) begin
      if (busy && cyc >= m_lat) begin
        seen++;
        if (seen > hold) resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == a0) begin
      chk("resp_timeout", 32'(k), 32'(0));
      return;
    end
    d = last_d;
    e = last_e;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          w0;
    logic [31:0] a;
    logic [1:0]  sz;

    for (int i = 0; i < NWORDS; i++) seed[i] = $urandom;
    rst = 1'b1;
    resp_ready = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_dc_we", 32'(dc_we), 32'd0);
    chk("rst_dc_waddr", dc_waddr, 32'h0);
    chk("rst_dc_wdata", dc_wdata, 32'h0);
    @(posedge clk); #1;

    w0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, d, e);
    chk("st_word_err", 32'(e), 32'd0);
    chk("st_word_we_cycles", 32'(we_cnt - w0), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, d, e);
    chk("ld_word", d, 32'hDEAD_BEEF);
    chk("ld_word_err", 32'(e), 32'd0);

    w0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_565A, 0, d, e);
    chk("st_byte_we_cycles", 32'(we_cnt - w0), 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, d, e);
    chk("ld_after_merge", d, 32'hDE5A_BEEF);

    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h8080_8080, 0, d, e);
    do_req(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 0, d, e);
    chk("ld_byte_signed", d, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 0, d, e);
    chk("ld_byte_unsigned", d, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 0, d, e);
    chk("ld_half_signed", d, 32'hFFFF_8080);

    w0 = we_cnt;
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 0, d, e);
    chk("mis_half_err", 32'(e), 32'd1);
    chk("mis_half_data", d, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFE_F00D, 0, d, e);
    chk("mis_word_err", 32'(e), 32'd1);
    chk("mis_we_cycles", 32'(we_cnt - w0), 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, d, e);
    chk("backpressure_data", d, 32'hDE5A_BEEF);

    // Reset in the middle of a sub-word store's merge cycle.
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344, 0, d, e);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h31; req_wdata = 32'h0000_00AA; resp_ready = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_merge_mem", mem[12], 32'h1122_3344);
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 0, d, e);
    chk("rst_merge_load", d, 32'h1122_3344);

    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), d, e);
    end

    @(posedge clk); #1;
    for (int i = 0; i < NWORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
